adder_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit adder among NUM_REQ requesters. Each requester presents an operand pair (A, B) on a valid/ready handshake. The block grants one requester, latches its operands and computes the 9-bit sum in the shared adder. It then returns the 8-bit sum, the carry-out and the requester id on a response handshake. It sits between the pad-level operand sources and the adder datapath.

---
 rtl/adder_share_pkg.sv | 27 ++
 rtl/rr_arbiter_onehot.sv | 34 +++
 rtl/adder_share_arbiter.sv | 116 +++++++++++
 tb/tb_adder_share_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
// Shared types for the adder-sharing arbiter: FSM encoding, widths and result record.
// Used by adder_share_arbiter and rr_arbiter_onehot.
package adder_share_pkg;

    localparam int OPER_W   = 8;
    localparam int SUM_W    = 9;
    localparam int MAX_ID_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Id is stored at the widest supported width (NUM_REQ up to 8).
    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [OPER_W-1:0]   sum;
        logic                carry;
    } result_t;

    function automatic logic [SUM_W-1:0] add_wide(input logic [OPER_W-1:0] a,
                                                  input logic [OPER_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin pick: first asserted req at or above rr_ptr, wrapping,
// returned as a one-hot grant plus its encoded index. All zero when disabled.
module rr_arbiter_onehot #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    index
);

    logic [ID_W-1:0] cand;
    logic            found;

    always_comb begin
        grant = '0;
        index = '0;
        cand  = '0;
        found = 1'b0;
        if (enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
                if (!found && req[cand]) begin
                    found       = 1'b1;
                    grant[cand] = 1'b1;
                    index       = cand;
                end
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one 8-bit adder among NUM_REQ requesters: grant, add, respond, one at a time.
// Build option: ADDER_SHARE_SAT_EN clamps rsp_sum to 0xFF when the carry is set.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*8-1:0]   req_a,
    input  logic [NUM_REQ*8-1:0]   req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [7:0]             rsp_sum,
    output logic                   rsp_carry,
    output logic                   busy,
    output logic [1:0]             fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high. req_ready only rises in IDLE for the chosen valid requester; rsp_valid
    // stays high with stable data until rsp_ready is seen.

    state_t               state, state_next;
    logic [ID_W-1:0]      rr_ptr;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      grant_idx;
    logic                 arb_en;
    logic                 accept;
    logic [OPER_W-1:0]    op_a, op_b;
    logic [ID_W-1:0]      op_id;
    logic [SUM_W-1:0]     sum_wide;
    result_t              res_d, res_q;
    logic                 unused_id;

    assign arb_en = (state == IDLE);
    assign accept = |grant;

    rr_arbiter_onehot #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .enable (arb_en),
        .grant  (grant),
        .index  (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = grant;
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
        fsm_state = state;
    end

    always_comb begin
        sum_wide    = add_wide(op_a, op_b);
        res_d       = '0;
        res_d.id    = MAX_ID_W'(op_id);
        res_d.carry = sum_wide[OPER_W];
`ifdef ADDER_SHARE_SAT_EN
        res_d.sum   = sum_wide[OPER_W] ? {OPER_W{1'b1}} : sum_wide[OPER_W-1:0];
`else
        res_d.sum   = sum_wide[OPER_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_id  <= '0;
            res_q  <= '0;
        end else begin
            if (state == IDLE && accept) begin
                op_a   <= req_a[int'(grant_idx)*OPER_W +: OPER_W];
                op_b   <= req_b[int'(grant_idx)*OPER_W +: OPER_W];
                op_id  <= grant_idx;
                rr_ptr <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            end
            if (state == EXEC) begin
                res_q <= res_d;
            end
        end
    end

    assign rsp_id    = res_q.id[ID_W-1:0];
    assign rsp_sum   = res_q.sum;
    assign rsp_carry = res_q.carry;
    assign unused_id = ^res_q.id;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized and directed bench for adder_share_arbiter against a transaction-level model.
// Honours ADDER_SHARE_SAT_EN in the expected sums.
module tb_adder_share_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int W  = IW + 8 + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*8-1:0]   req_a = '0;
    logic [N*8-1:0]   req_b = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [IW-1:0]    rsp_id;
    logic [7:0]       rsp_sum;
    logic             rsp_carry;
    logic             busy;
    logic [1:0]       fsm_state;

    adder_share_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    // Model: phase 0 = waiting for an accept, 1 = accepted last edge, 2 = result offered.
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_phase  = 0;
    int          m_ptr    = 0;
    bit          m_after_rst = 1'b0;
    logic [W-1:0] exp_q[$];
    int          grant_log[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_result(input int id, input int a, input int b);
        int   s;
        logic c;
        logic [7:0] sv;
        s  = a + b;
        c  = (s > 255);
        sv = 8'(s % 256);
`ifdef ADDER_SHARE_SAT_EN
        if (c) sv = 8'hFF;
`endif
        return {IW'(id), sv, c};
    endfunction

    // Whom the model expects to be chosen: scan requesters in rotated order from m_ptr.
    function automatic int model_pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic step(input logic [N-1:0] v, input logic [N*8-1:0] a,
                        input logic [N*8-1:0] b, input logic rr, input logic do_rst);
        int           pick;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        rst       = do_rst;
        #1;
        pick      = (m_phase == 0) ? model_pick(v) : -1;
        exp_ready = '0;
        if (pick >= 0) exp_ready[pick] = 1'b1;
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
        check_eq("busy", 32'(busy), 32'(m_phase != 0));
        check_eq("fsm_state", 32'(fsm_state), 32'(m_phase));
        if (m_after_rst) begin
            check_eq("rst_rsp_data", {21'd0, rsp_id, rsp_sum, rsp_carry}, 32'd0);
            m_after_rst = 1'b0;
        end
        if (m_phase == 2) begin
            if (exp_q.size() == 0) check_eq("exp_q_empty", 32'd1, 32'd0);
            else check_eq("rsp_data", {21'd0, rsp_id, rsp_sum, rsp_carry}, 32'(exp_q[0]));
        end
        @(posedge clk);
        if (do_rst) begin
            m_phase = 0;
            m_ptr   = 0;
            exp_q.delete();
            m_after_rst = 1'b1;
        end else begin
            case (m_phase)
                0: if (pick >= 0) begin
                    exp_q.push_back(model_result(pick, int'(a[pick*8 +: 8]), int'(b[pick*8 +: 8])));
                    grant_log.push_back(pick);
                    m_ptr   = (pick + 1) % N;
                    m_phase = 1;
                end
                1: m_phase = 2;
                default: if (rr) begin
                    void'(exp_q.pop_front());
                    m_phase = 0;
                end
            endcase
        end
    endtask

    function automatic logic [N*8-1:0] rand_ops();
        logic [N*8-1:0] r;
        for (int i = 0; i < N; i++) r[i*8 +: 8] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    initial begin
        logic [N*8-1:0] a, b;
        int base;

        // Clock/reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        m_after_rst = 1'b1;

        // Single request on requester 1: 0x12 + 0x34
        a = '0; b = '0;
        a[15:8] = 8'h12; b[15:8] = 8'h34;
        step(4'b0010, a, b, 1'b0, 1'b0);
        step(4'b0000, a, b, 1'b0, 1'b0);
        step(4'b0000, a, b, 1'b1, 1'b0);
        check_eq("single_id", 32'(rsp_id), 32'd1);
        check_eq("single_sum", 32'(rsp_sum), 32'h46);

        // Overflow cases on requester 2 (pointer is now 2)
        a[23:16] = 8'hFF; b[23:16] = 8'h01;
        step(4'b0100, a, b, 1'b1, 1'b0);
        step(4'b0000, a, b, 1'b1, 1'b0);
        step(4'b0000, a, b, 1'b1, 1'b0);
        a[7:0] = 8'hFF; b[7:0] = 8'hFF;
        step(4'b0001, a, b, 1'b1, 1'b0);
        step(4'b0000, a, b, 1'b1, 1'b0);
        step(4'b0000, a, b, 1'b1, 1'b0);

        // Fairness from reset: all valid, 12 grants in order 0,1,2,3,...
        step('0, a, b, 1'b1, 1'b1);
        base = grant_log.size();
        for (int i = 0; i < 60 && grant_log.size() < base + 12; i++)
            step(4'b1111, rand_ops(), rand_ops(), 1'b1, 1'b0);
        check_eq("fair_count", 32'(grant_log.size() - base), 32'd12);
        for (int i = 0; i < 12 && base + i < grant_log.size(); i++)
            check_eq("fair_order", 32'(grant_log[base + i]), 32'(i % 4));

        // Backpressure: hold rsp_ready low 5 cycles in RESP while everyone requests
        while (m_phase != 0) step(4'b0000, a, b, 1'b1, 1'b0);
        step(4'b1111, rand_ops(), rand_ops(), 1'b0, 1'b0);
        step(4'b1111, a, b, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(4'b1111, rand_ops(), rand_ops(), 1'b0, 1'b0);
        step(4'b1111, a, b, 1'b1, 1'b0);
        base = grant_log.size();
        step(4'b1111, a, b, 1'b0, 1'b0);
        check_eq("bp_regrant", 32'(grant_log.size() - base), 32'd1);
        step(4'b0000, a, b, 1'b1, 1'b0);
        step(4'b0000, a, b, 1'b1, 1'b0);

        // Sparse wrap: grant 3, then only 1 and 2 valid
        step(4'b1000, a, b, 1'b1, 1'b0);
        step(4'b0000, a, b, 1'b1, 1'b0);
        step(4'b0000, a, b, 1'b1, 1'b0);
        base = grant_log.size();
        for (int i = 0; i < 6; i++) step(4'b0110, rand_ops(), rand_ops(), 1'b1, 1'b0);
        check_eq("wrap_count", 32'(grant_log.size() - base), 32'd2);
        if (grant_log.size() >= base + 2) begin
            check_eq("wrap_first", 32'(grant_log[base]), 32'd1);
            check_eq("wrap_second", 32'(grant_log[base + 1]), 32'd2);
        end

        // Reset mid-EXEC: transaction dropped, next grant from 0
        while (m_phase != 0) step(4'b0000, a, b, 1'b1, 1'b0);
        step(4'b0100, rand_ops(), rand_ops(), 1'b1, 1'b0);
        check_eq("pre_rst_exec", 32'(m_phase), 32'd1);
        step(4'b0000, a, b, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0000, a, b, 1'b1, 1'b0);
        base = grant_log.size();
        step(4'b1111, rand_ops(), rand_ops(), 1'b1, 1'b0);
        if (grant_log.size() > base) check_eq("post_rst_grant", 32'(grant_log[base]), 32'd0);
        else check_eq("post_rst_grant_seen", 32'd0, 32'd1);

        // Random traffic including dropped requests and random backpressure
        for (int i = 0; i < 2000; i++) begin
            step(N'($urandom_range(0, (1 << N) - 1)), rand_ops(), rand_ops(),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
